// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin valid/ready delivery.
// Optional input synchronizer: define EDGE_EVENT_ARB_SYNC_EN.
module edge_event_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int ID_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] data_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [ID_W-1:0]   evt_id_o,
   output logic [NUM_CH-1:0] pending_o,
   output logic [NUM_CH-1:0] overflow_o
);

   localparam int SW = ID_W + 1;

   typedef enum logic {
      S_IDLE,
      S_OFFER
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [NUM_CH-1:0] w_in;
   logic [NUM_CH-1:0] r_dly;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_clr;
   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_ovf;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_id;
   logic [ID_W-1:0]   w_win;
   logic [ID_W-1:0]   w_cand;
   logic [SW-1:0]     w_sum;
   logic              w_found;
   logic              w_load;
   logic              w_ack;

`ifdef EDGE_EVENT_ARB_SYNC_EN
   logic [NUM_CH-1:0] r_sync1;
   logic [NUM_CH-1:0] r_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= data_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_in = r_sync2;
`else
   assign w_in = data_i;
`endif

   assign w_rise = w_in & ~r_dly;

   // First pending channel at or after r_ptr, wrapping modulo NUM_CH.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sum = {1'b0, r_ptr} + SW'(i);
         if (w_sum >= SW'(NUM_CH)) begin
            w_sum = w_sum - SW'(NUM_CH);
         end
         w_cand = w_sum[ID_W-1:0];
         if (!w_found && r_pend[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_ack      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (|r_pend) begin
               w_load     = 1'b1;
               w_state_nx = S_OFFER;
            end
         end
         S_OFFER: begin
            if (evt_ready_i) begin
               w_ack      = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      w_clr = '0;
      if (w_ack) begin
         w_clr[r_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dly  <= '0;
         r_pend <= '0;
         r_ovf  <= '0;
         r_ptr  <= '0;
         r_id   <= '0;
      end else begin
         r_dly  <= w_in;
         // A rise coinciding with its own clear is a fresh event, not a loss.
         r_pend <= (r_pend & ~w_clr) | w_rise;
         r_ovf  <= r_ovf | (w_rise & r_pend & ~w_clr);
         if (w_load) begin
            r_id <= w_win;
         end
         if (w_ack) begin
            r_ptr <= (r_id == ID_W'(NUM_CH - 1)) ? '0 : r_id + 1'b1;
         end
      end
   end

   assign evt_valid_o = (r_state == S_OFFER);
   assign evt_id_o    = r_id;
   assign pending_o   = r_pend;
   assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter (NUM_CH = 4).
module tb_edge_event_arbiter;

`ifdef EDGE_EVENT_ARB_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] data_i;
   logic       evt_valid_o;
   logic       evt_ready_i;
   logic [1:0] evt_id_o;
   logic [3:0] pending_o;
   logic [3:0] overflow_o;

   int n_chk = 0;
   int n_bad = 0;
   int n_evt = 0;
   int e0;
   int q[$];

   edge_event_arbiter #(.NUM_CH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .data_i      (data_i),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_id_o    (evt_id_o),
      .pending_o   (pending_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Handshakes are observed mid-cycle, before the edge that completes them.
   always @(negedge clk) begin
      if (!reset && evt_valid_o && evt_ready_i) begin
         n_evt++;
         if (q.size() == 0) check("sb_extra", {30'd0, evt_id_o}, 32'hffff);
         else check("sb_id", {30'd0, evt_id_o}, q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] m);
      data_i = m;
      tick();
      data_i = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      evt_ready_i = 1'b1;
      while ((evt_valid_o || pending_o != 0 || q.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      check("drain_done", {31'd0, n < 200}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      data_i = '0;
      evt_ready_i = 1'b1;
      repeat (3) tick();
      check("rst_valid", {31'd0, evt_valid_o}, 0);
      check("rst_id", {30'd0, evt_id_o}, 0);
      check("rst_pend", {28'd0, pending_o}, 0);
      check("rst_ovf", {28'd0, overflow_o}, 0);
      reset = 1'b0;
      tick();

      // single event on channel 2
      q.push_back(2);
      pulse(4'b0100);
      repeat (LAT) tick();
      check("se_pend", {28'd0, pending_o}, 4'b0100);
      check("se_val0", {31'd0, evt_valid_o}, 0);
      tick();
      check("se_val1", {31'd0, evt_valid_o}, 1);
      check("se_id", {30'd0, evt_id_o}, 2);
      tick();
      check("se_val2", {31'd0, evt_valid_o}, 0);
      check("se_pend0", {28'd0, pending_o}, 0);
      drain();

      // round robin
      do_reset();
      q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3);
      pulse(4'b1111);
      drain();
      q.push_back(0); q.push_back(3);
      pulse(4'b1001);
      drain();
      check("rr_ovf", {28'd0, overflow_o}, 0);

      // backpressure
      evt_ready_i = 1'b0;
      q.push_back(1);
      pulse(4'b0010);
      repeat (LAT + 1) tick();
      q.push_back(0);
      pulse(4'b0001);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", {31'd0, evt_valid_o}, 1);
         check("bp_id", {30'd0, evt_id_o}, 1);
         tick();
      end
      check("bp_pend", {28'd0, pending_o}, 4'b0011);
      drain();

      // overflow: second edge while id 2 is still pending
      e0 = n_evt;
      evt_ready_i = 1'b0;
      q.push_back(2);
      pulse(4'b0100);
      repeat (LAT + 1) tick();
      check("of_valid", {31'd0, evt_valid_o}, 1);
      check("of_id", {30'd0, evt_id_o}, 2);
      pulse(4'b0100);
      tick();
      pulse(4'b0100);
      repeat (LAT + 1) tick();
      check("of_ovf", {28'd0, overflow_o}, 4'b0100);
      check("of_pend", {28'd0, pending_o}, 4'b0100);
      drain();
      check("of_count", n_evt - e0, 1);

      // rise in the exact acceptance cycle
      do_reset();
      e0 = n_evt;
      evt_ready_i = 1'b0;
      q.push_back(2);
      pulse(4'b0100);
      repeat (LAT + 1) tick();
      check("sc_valid", {31'd0, evt_valid_o}, 1);
      q.push_back(2);
      data_i = 4'b0100;
      repeat (LAT) begin
         tick();
         data_i = '0;
      end
      evt_ready_i = 1'b1;
      tick();
      data_i = '0;
      check("sc_pend", {28'd0, pending_o}, 4'b0100);
      check("sc_ovf", {28'd0, overflow_o}, 0);
      check("sc_idle", {31'd0, evt_valid_o}, 0);
      drain();
      check("sc_count", n_evt - e0, 2);

      // input held high through reset
      reset = 1'b1;
      data_i = 4'b0001;
      repeat (3) tick();
      e0 = n_evt;
      reset = 1'b0;
      q.push_back(0);
      drain();
      repeat (6) tick();
      check("hr_count", n_evt - e0, 1);
      data_i = '0;
      tick();

      // reset while offering, with an overflow recorded
      evt_ready_i = 1'b0;
      pulse(4'b0010);
      repeat (LAT + 1) tick();
      pulse(4'b0010);
      tick();
      pulse(4'b0010);
      repeat (LAT + 1) tick();
      check("rm_valid", {31'd0, evt_valid_o}, 1);
      check("rm_ovf1", {28'd0, overflow_o}, 4'b0010);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rm_valid0", {31'd0, evt_valid_o}, 0);
      check("rm_pend", {28'd0, pending_o}, 0);
      check("rm_ovf", {28'd0, overflow_o}, 0);
      tick();
      check("sb_left", q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
